// File: rtl/jelly_img_gamma_table_writer.sv
// Loads gamma LUT entries into the inactive bank of a double-banked table and swaps banks at frame_start.
// Optional identity-ramp fill mode is enabled by defining JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN.
module jelly_img_gamma_table_writer #(
   parameter int S_DATA_WIDTH = 8,
   parameter int M_DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    frame_start,
`ifdef JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN
   input  logic                    fill,
`endif
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [M_DATA_WIDTH-1:0] s_data,
   output logic                    busy,
   output logic                    done,
   output logic                    active_bank,
   output logic                    mem_en,
   output logic [S_DATA_WIDTH:0]   mem_addr,
   output logic [M_DATA_WIDTH-1:0] mem_din
);

`ifdef JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_SWAP = 2'd2,
      ST_FILL      = 2'd3
   } state_t;

   localparam int SH_UP  = (M_DATA_WIDTH > S_DATA_WIDTH) ? (M_DATA_WIDTH - S_DATA_WIDTH) : 0;
   localparam int SH_REP = (M_DATA_WIDTH > S_DATA_WIDTH && 2*S_DATA_WIDTH > M_DATA_WIDTH)
                           ? (2*S_DATA_WIDTH - M_DATA_WIDTH) : 0;
   localparam int SH_DN  = (M_DATA_WIDTH > S_DATA_WIDTH) ? 0 : (S_DATA_WIDTH - M_DATA_WIDTH);

   // Identity ramp: widen by high-bit replication, or narrow by dropping LSBs.
   function automatic logic [M_DATA_WIDTH-1:0] ramp_value(input logic [S_DATA_WIDTH-1:0] idx);
      logic [M_DATA_WIDTH+S_DATA_WIDTH-1:0] w_wide;
      w_wide = {{M_DATA_WIDTH{1'b0}}, idx};
      if (M_DATA_WIDTH > S_DATA_WIDTH) begin
         w_wide = (w_wide << SH_UP) | (w_wide >> SH_REP);
      end else begin
         w_wide = w_wide >> SH_DN;
      end
      return w_wide[M_DATA_WIDTH-1:0];
   endfunction
`else
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_SWAP = 2'd2
   } state_t;
`endif

   localparam logic [S_DATA_WIDTH-1:0] CNT_LAST = {S_DATA_WIDTH{1'b1}};

   state_t                    r_state;
   state_t                    w_state_next;
   logic [S_DATA_WIDTH-1:0]   r_cnt;
   logic [S_DATA_WIDTH-1:0]   w_cnt_next;
   logic                      w_we;
   logic [M_DATA_WIDTH-1:0]   w_wdata;
   logic                      w_swap;
   logic                      r_busy;
   logic                      r_swapped;
   logic                      r_done;
   logic                      r_active_bank;
   logic                      r_mem_en;
   logic [S_DATA_WIDTH:0]     r_mem_addr;
   logic [M_DATA_WIDTH-1:0]   r_mem_din;

   // Next-state, write request and bank-swap decode; abort always wins.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_we         = 1'b0;
      w_wdata      = {M_DATA_WIDTH{1'b0}};
      w_swap       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_next = {S_DATA_WIDTH{1'b0}};
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (start) begin
               w_state_next = ST_LOAD;
`ifdef JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN
            end else if (fill) begin
               w_state_next = ST_FILL;
`endif
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = {S_DATA_WIDTH{1'b0}};
            end else if (s_valid) begin
               w_we       = 1'b1;
               w_wdata    = s_data;
               w_cnt_next = r_cnt + S_DATA_WIDTH'(1);
               if (r_cnt == CNT_LAST) begin
                  w_state_next = ST_WAIT_SWAP;
               end else begin
                  w_state_next = ST_LOAD;
               end
            end else begin
               w_state_next = ST_LOAD;
            end
         end
`ifdef JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN
         ST_FILL: begin
            if (abort) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = {S_DATA_WIDTH{1'b0}};
            end else begin
               w_we       = 1'b1;
               w_wdata    = ramp_value(r_cnt);
               w_cnt_next = r_cnt + S_DATA_WIDTH'(1);
               if (r_cnt == CNT_LAST) begin
                  w_state_next = ST_WAIT_SWAP;
               end else begin
                  w_state_next = ST_FILL;
               end
            end
         end
`endif
         ST_WAIT_SWAP: begin
            if (abort) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = {S_DATA_WIDTH{1'b0}};
            end else if (frame_start) begin
               w_state_next = ST_IDLE;
               w_swap       = 1'b1;
            end else begin
               w_state_next = ST_WAIT_SWAP;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = {S_DATA_WIDTH{1'b0}};
         end
      endcase
   end

   // State, counter, LUT write port and status registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= {S_DATA_WIDTH{1'b0}};
         r_busy        <= 1'b0;
         r_swapped     <= 1'b0;
         r_done        <= 1'b0;
         r_active_bank <= 1'b0;
         r_mem_en      <= 1'b0;
         r_mem_addr    <= {(S_DATA_WIDTH+1){1'b0}};
         r_mem_din     <= {M_DATA_WIDTH{1'b0}};
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_busy        <= (w_state_next != ST_IDLE);
         r_swapped     <= w_swap;
         r_done        <= r_swapped;
         r_active_bank <= r_active_bank ^ w_swap;
         r_mem_en      <= w_we;
         // The write bank is the one the pixel pipeline is not reading.
         r_mem_addr    <= w_we ? {~r_active_bank, r_cnt} : {(S_DATA_WIDTH+1){1'b0}};
         r_mem_din     <= w_wdata;
      end
   end

   assign s_ready     = (r_state == ST_LOAD);
   assign busy        = r_busy;
   assign done        = r_done;
   assign active_bank = r_active_bank;
   assign mem_en      = r_mem_en;
   assign mem_addr    = r_mem_addr;
   assign mem_din     = r_mem_din;

endmodule

// File: tb/tb_jelly_img_gamma_table_writer.sv
// Randomized self-checking bench for jelly_img_gamma_table_writer against a queue-based table/bank model.
module tb_jelly_img_gamma_table_writer;
   localparam int S = 8;
`ifdef JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN
   localparam int M = 10;
`else
   localparam int M = 8;
`endif
   localparam int DEPTH = 1 << S;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic         abort;
   logic         frame_start;
   logic         fill;
   logic         s_valid;
   logic         s_ready;
   logic [M-1:0] s_data;
   logic         busy;
   logic         done;
   logic         active_bank;
   logic         mem_en;
   logic [S:0]   mem_addr;
   logic [M-1:0] mem_din;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   logic         exp_bank;
   logic [S:0]   wq_addr[$];
   logic [M-1:0] wq_din[$];
   int           wq_cyc[$];
   logic [M-1:0] exp_q[$];
   int           hs_q[$];

   jelly_img_gamma_table_writer #(.S_DATA_WIDTH(S), .M_DATA_WIDTH(M)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .frame_start(frame_start),
`ifdef JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN
      .fill(fill),
`endif
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .busy(busy), .done(done),
      .active_bank(active_bank), .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: a write registered at edge E is seen here with cyc == E.
   always @(negedge clk) begin
      if (mem_en === 1'b1) begin
         wq_addr.push_back(mem_addr);
         wq_din.push_back(mem_din);
         wq_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_queues;
      wq_addr.delete(); wq_din.delete(); wq_cyc.delete();
      exp_q.delete(); hs_q.delete();
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Streams entries until n are accepted; optional abort with a handshake and start/frame_start poke.
   task automatic feed(input int n, input int duty, input bit ramp_src, input int abort_at, input int poke_at);
      int acc;
      int guard;
      bit hs;
      bit ab;
      acc = 0;
      guard = 0;
      while (acc < n && guard < 4000) begin
         s_valid     = ((guard % duty) == 0);
         s_data      = ramp_src ? M'(DEPTH - 1 - acc) : M'($urandom);
         ab          = (abort_at >= 0) && (acc == abort_at) && s_valid && s_ready;
         abort       = ab;
         start       = (acc == poke_at);
         frame_start = (acc == poke_at);
         hs          = s_valid && s_ready;
         tick();
         guard++;
         if (hs && !ab) begin
            exp_q.push_back(s_data);
            hs_q.push_back(cyc);
            acc++;
         end
         if (ab) acc = n;
      end
      s_valid = 1'b0; abort = 1'b0; start = 1'b0; frame_start = 1'b0;
      n_cmp++;
      if (guard >= 4000) begin
         n_fail++;
         $display("FAIL feed_timeout: accepted %0d entries, required %0d", acc, n);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) tick();
      exp_bank = 1'b0;
      n_cmp++;
      if ({busy, done, active_bank, mem_en, mem_addr, mem_din, s_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b bank=%b en=%b addr=%h din=%h rdy=%b, required all 0",
                  busy, done, active_bank, mem_en, mem_addr, mem_din, s_ready);
      end
      reset_n = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if ({busy, active_bank, mem_en, s_ready} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b bank=%b en=%b rdy=%b, required 0", busy, active_bank, mem_en, s_ready);
      end
   endtask

   task automatic test_load_full;
      clear_queues();
      pulse_start();
      n_cmp++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b, required 1", busy); end
      feed(DEPTH, 1, 1'b1, -1, -1);
      repeat (5) tick();
      n_cmp++;
      if (wq_addr.size() != DEPTH) begin
         n_fail++; $display("FAIL full_write_count: got %0d, required %0d", wq_addr.size(), DEPTH);
      end
      for (int k = 0; k < wq_addr.size() && k < DEPTH; k++) begin
         n_cmp++;
         if (wq_addr[k] !== {~exp_bank, S'(k)} || wq_din[k] !== M'(DEPTH - 1 - k) || wq_cyc[k] != hs_q[k]) begin
            n_fail++;
            $display("FAIL full_write[%0d]: got addr=%h din=%h cyc=%0d, required addr=%h din=%h cyc=%0d",
                     k, wq_addr[k], wq_din[k], wq_cyc[k], {~exp_bank, S'(k)}, M'(DEPTH - 1 - k), hs_q[k]);
         end
      end
      n_cmp++;
      if (busy !== 1'b1 || active_bank !== exp_bank || done !== 1'b0) begin
         n_fail++;
         $display("FAIL no_early_swap: got busy=%b bank=%b done=%b, required busy=1 bank=%b done=0", busy, active_bank, done, exp_bank);
      end
   endtask

   task automatic test_swap_and_reload;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      exp_bank = ~exp_bank;
      n_cmp++;
      if (active_bank !== exp_bank || done !== 1'b0) begin
         n_fail++; $display("FAIL swap_bank: got bank=%b done=%b, required bank=%b done=0", active_bank, done, exp_bank);
      end
      tick();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL done_pulse: got done=%b busy=%b, required done=1 busy=0", done, busy);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b, required 0", done); end
      clear_queues();
      pulse_start();
      feed(DEPTH, 1, 1'b0, -1, -1);
      repeat (3) tick();
      n_cmp++;
      if (wq_addr.size() != DEPTH) begin
         n_fail++; $display("FAIL reload_count: got %0d, required %0d", wq_addr.size(), DEPTH);
      end
      for (int k = 0; k < wq_addr.size() && k < DEPTH; k++) begin
         n_cmp++;
         if (wq_addr[k] !== {~exp_bank, S'(k)} || wq_din[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL reload_write[%0d]: got addr=%h din=%h, required addr=%h din=%h",
                     k, wq_addr[k], wq_din[k], {~exp_bank, S'(k)}, exp_q[k]);
         end
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      exp_bank = ~exp_bank;
      n_cmp++;
      if (active_bank !== exp_bank) begin
         n_fail++; $display("FAIL reload_swap: got bank=%b, required %b", active_bank, exp_bank);
      end
      repeat (2) tick();
   endtask

   task automatic test_throttled;
      clear_queues();
      pulse_start();
      feed(DEPTH, 3, 1'b0, -1, -1);
      repeat (3) tick();
      n_cmp++;
      if (wq_addr.size() != DEPTH) begin
         n_fail++; $display("FAIL throttled_count: got %0d, required %0d", wq_addr.size(), DEPTH);
      end
      for (int k = 0; k < wq_addr.size() && k < DEPTH; k++) begin
         n_cmp++;
         if (wq_addr[k] !== {~exp_bank, S'(k)} || wq_din[k] !== exp_q[k] || wq_cyc[k] != hs_q[k]) begin
            n_fail++;
            $display("FAIL throttled_write[%0d]: got addr=%h din=%h cyc=%0d, required addr=%h din=%h cyc=%0d",
                     k, wq_addr[k], wq_din[k], wq_cyc[k], {~exp_bank, S'(k)}, exp_q[k], hs_q[k]);
         end
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      exp_bank = ~exp_bank;
      repeat (2) tick();
      n_cmp++;
      if (active_bank !== exp_bank || busy !== 1'b0) begin
         n_fail++; $display("FAIL throttled_swap: got bank=%b busy=%b, required bank=%b busy=0", active_bank, busy, exp_bank);
      end
   endtask

   task automatic test_abort;
      clear_queues();
      pulse_start();
      feed(101, 1, 1'b0, 100, -1);
      repeat (3) tick();
      n_cmp++;
      if (wq_addr.size() != 100) begin
         n_fail++; $display("FAIL abort_count: got %0d writes, required 100", wq_addr.size());
      end
      for (int k = 0; k < wq_addr.size() && k < 100; k++) begin
         n_cmp++;
         if (wq_addr[k] !== {~exp_bank, S'(k)} || wq_din[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL abort_write[%0d]: got addr=%h din=%h, required addr=%h din=%h",
                     k, wq_addr[k], wq_din[k], {~exp_bank, S'(k)}, exp_q[k]);
         end
      end
      n_cmp++;
      if (busy !== 1'b0 || active_bank !== exp_bank || done !== 1'b0) begin
         n_fail++; $display("FAIL abort_state: got busy=%b bank=%b done=%b, required busy=0 bank=%b done=0", busy, active_bank, done, exp_bank);
      end
      clear_queues();
      pulse_start();
      feed(5, 1, 1'b0, -1, -1);
      repeat (2) tick();
      n_cmp++;
      if (wq_addr.size() != 5) begin
         n_fail++; $display("FAIL restart_count: got %0d, required 5", wq_addr.size());
      end
      for (int k = 0; k < wq_addr.size() && k < 5; k++) begin
         n_cmp++;
         if (wq_addr[k] !== {~exp_bank, S'(k)}) begin
            n_fail++; $display("FAIL restart_addr[%0d]: got %h, required %h", k, wq_addr[k], {~exp_bank, S'(k)});
         end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   task automatic test_ignore_and_reset;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if (active_bank !== exp_bank || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_frame_start: got bank=%b done=%b busy=%b, required bank=%b done=0 busy=0", active_bank, done, busy, exp_bank);
      end
      clear_queues();
      pulse_start();
      feed(DEPTH, 1, 1'b0, -1, 50);
      repeat (3) tick();
      n_cmp++;
      if (wq_addr.size() != DEPTH || active_bank !== exp_bank) begin
         n_fail++; $display("FAIL load_pokes: got %0d writes bank=%b, required %0d writes bank=%b", wq_addr.size(), active_bank, DEPTH, exp_bank);
      end
      for (int k = 0; k < wq_addr.size() && k < DEPTH; k++) begin
         n_cmp++;
         if (wq_addr[k] !== {~exp_bank, S'(k)} || wq_din[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL poke_write[%0d]: got addr=%h din=%h, required addr=%h din=%h",
                     k, wq_addr[k], wq_din[k], {~exp_bank, S'(k)}, exp_q[k]);
         end
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      pulse_start();
      feed(30, 1, 1'b0, -1, -1);
      s_valid = 1'b1;
      reset_n = 1'b0;
      #1;
      exp_bank = 1'b0;
      n_cmp++;
      if ({busy, done, active_bank, mem_en, mem_addr, mem_din, s_ready} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got busy=%b done=%b bank=%b en=%b addr=%h din=%h rdy=%b, required all 0",
                  busy, done, active_bank, mem_en, mem_addr, mem_din, s_ready);
      end
      s_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (2) tick();
   endtask

`ifdef JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN
   task automatic test_fill;
      int exp_v;
      clear_queues();
      fill = 1'b1;
      tick();
      fill = 1'b0;
      repeat (DEPTH + 4) tick();
      n_cmp++;
      if (wq_addr.size() != DEPTH) begin
         n_fail++; $display("FAIL fill_count: got %0d, required %0d", wq_addr.size(), DEPTH);
      end
      for (int k = 0; k < wq_addr.size() && k < DEPTH; k++) begin
         exp_v = ((k << (M - S)) | (k >> (2 * S - M))) & ((1 << M) - 1);
         n_cmp++;
         if (wq_addr[k] !== {~exp_bank, S'(k)} || wq_din[k] !== M'(exp_v) || wq_cyc[k] != wq_cyc[0] + k) begin
            n_fail++;
            $display("FAIL fill_write[%0d]: got addr=%h din=%h, required addr=%h din=%h",
                     k, wq_addr[k], wq_din[k], {~exp_bank, S'(k)}, M'(exp_v));
         end
      end
      n_cmp++;
      if (wq_din.size() == DEPTH && (wq_din[8'h80] !== 10'h202 || wq_din[8'hFF] !== 10'h3FF)) begin
         n_fail++; $display("FAIL fill_points: got %h/%h, required 202/3ff", wq_din[8'h80], wq_din[8'hFF]);
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      exp_bank = ~exp_bank;
      n_cmp++;
      if (active_bank !== exp_bank) begin
         n_fail++; $display("FAIL fill_swap: got %b, required %b", active_bank, exp_bank);
      end
      repeat (2) tick();
   endtask
`endif

   initial begin
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; frame_start = 1'b0;
      fill = 1'b0; s_valid = 1'b0; s_data = '0; exp_bank = 1'b0;
      test_reset();
      test_load_full();
      test_swap_and_reload();
      test_throttled();
      test_abort();
      test_ignore_and_reset();
`ifdef JELLY_IMG_GAMMA_TABLE_WRITER_FILL_EN
      test_fill();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
